// File: rtl/press_run_ctrl_pkg.sv
// Shared definitions for the stopwatch run-control / lap-capture stage:
// state encoding, lap word layout and default buffer depth.
package press_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam int LAP_TW        = 16;
  localparam int DEFAULT_DEPTH = 4;

  // Lap word layout: dsec [15:12], sec [11:8], secd [7:4], secm [3:0]
  typedef struct packed {
    logic [3:0] dsec;
    logic [3:0] sec;
    logic [3:0] secd;
    logic [3:0] secm;
  } lap_t;

endpackage

// File: rtl/press_run_ctrl_lap_buf.sv
// Lap register file: one synchronous write port, one combinational read port,
// cleared asynchronously by clrn.
module press_run_ctrl_lap_buf
  import press_run_ctrl_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  parameter int  TW    = LAP_TW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          TFF_clk,
  input  logic          clrn,
  input  logic          we,
  input  logic [AW-1:0] wr_ptr,
  input  logic [TW-1:0] time_bcd,
  input  logic [AW-1:0] rd_addr,
  output logic [TW-1:0] rd_data
);

  logic [TW-1:0] mem_r [DEPTH];

  // Entry storage with asynchronous clear
  always_ff @(posedge TFF_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {TW{1'b0}};
      end
    end else if (we) begin
      mem_r[wr_ptr] <= time_bcd;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/press_run_ctrl.sv
// Key-press driven run/stop FSM for the stopwatch: drives the count enable,
// captures lap times on every stop and latches terminally on counter overflow.
module press_run_ctrl
  import press_run_ctrl_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  parameter int  TW    = LAP_TW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          TFF_clk,
  input  logic          clrn,
  input  logic [TW-1:0] time_bcd,
  input  logic          ovf,
  input  logic [AW-1:0] rd_idx,
  output logic          enable,
  output logic [TW-1:0] lap_time,
  output logic [AW:0]   lap_cnt,
  output logic          halted
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic          capture_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_addr_s;
  logic [TW-1:0] rd_data_s;
  logic          rd_valid_s;

  // Next state and capture strobe; overflow outranks any press
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    if (ovf && (state_r != HALT)) begin
      state_nxt_s = HALT;
      capture_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = RUN;
        RUN: begin
          state_nxt_s = STOP;
          capture_s   = 1'b1;
        end
        STOP:    state_nxt_s = RUN;
        HALT:    state_nxt_s = HALT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, registered outputs, write pointer and saturating lap count
  always_ff @(posedge TFF_clk or negedge clrn) begin
    if (!clrn) begin
      state_r  <= IDLE;
      enable   <= 1'b0;
      halted   <= 1'b0;
      wr_ptr_r <= {AW{1'b0}};
      lap_cnt  <= {(AW+1){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      enable  <= (state_nxt_s == RUN);
      halted  <= (state_nxt_s == HALT);
      if (capture_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        lap_cnt  <= (lap_cnt == CNT_FULL) ? CNT_FULL : lap_cnt + CNT_ONE;
      end
    end
  end

  // Newest-first read address; indices past the valid count read as zero
  always_comb begin
    rd_addr_s  = wr_ptr_r - PTR_ONE - rd_idx;
    rd_valid_s = ({1'b0, rd_idx} < lap_cnt);
    lap_time   = rd_valid_s ? rd_data_s : {TW{1'b0}};
  end

  press_run_ctrl_lap_buf #(
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_lap_buf (
    .TFF_clk  (TFF_clk),
    .clrn     (clrn),
    .we       (capture_s),
    .wr_ptr   (wr_ptr_r),
    .time_bcd (time_bcd),
    .rd_addr  (rd_addr_s),
    .rd_data  (rd_data_s)
  );

endmodule

// File: tb/tb_press_run_ctrl.sv
// Scoreboard bench for press_run_ctrl: a DEPTH=4 and a DEPTH=2 instance, each
// press pushes the model's expected outputs, popped and compared after the edge.
`timescale 1ns/100ps
module tb_press_run_ctrl;

  typedef struct packed {
    logic       en;
    logic       halt;
    logic [2:0] cnt;
  } exp_t;

  logic        clk_a, clk_b, clrn, ovf;
  logic [15:0] time_bcd;
  logic [1:0]  rd_idx_a;
  logic [0:0]  rd_idx_b;
  logic        enable_a, halted_a, enable_b, halted_b;
  logic [15:0] lap_time_a, lap_time_b;
  logic [2:0]  lap_cnt_a;
  logic [1:0]  lap_cnt_b;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  int          mst[2];
  logic [15:0] lq_a[$];
  logic [15:0] lq_b[$];

  press_run_ctrl #(.DEPTH(4), .TW(16)) dut_a (
    .TFF_clk(clk_a), .clrn(clrn), .time_bcd(time_bcd), .ovf(ovf), .rd_idx(rd_idx_a),
    .enable(enable_a), .lap_time(lap_time_a), .lap_cnt(lap_cnt_a), .halted(halted_a)
  );

  press_run_ctrl #(.DEPTH(2), .TW(16)) dut_b (
    .TFF_clk(clk_b), .clrn(clrn), .time_bcd(time_bcd), .ovf(ovf), .rd_idx(rd_idx_b),
    .enable(enable_b), .lap_time(lap_time_b), .lap_cnt(lap_cnt_b), .halted(halted_b)
  );

  function automatic exp_t observe(input bit sel);
    exp_t o;
    if (sel) begin
      o.en = enable_b; o.halt = halted_b; o.cnt = {1'b0, lap_cnt_b};
    end else begin
      o.en = enable_a; o.halt = halted_a; o.cnt = lap_cnt_a;
    end
    return o;
  endfunction

  function automatic logic [15:0] model_lap(input bit sel, input int idx);
    if (sel) return (idx < lq_b.size()) ? lq_b[idx] : 16'h0000;
    else     return (idx < lq_a.size()) ? lq_a[idx] : 16'h0000;
  endfunction

  function automatic logic [15:0] read_lap(input bit sel);
    return sel ? lap_time_b : lap_time_a;
  endfunction

  task automatic set_rd(input bit sel, input int idx);
    if (sel) rd_idx_b = 1'(idx);
    else     rd_idx_a = 2'(idx);
  endtask

  task automatic model_reset();
    mst[0] = 0; mst[1] = 0;
    lq_a.delete(); lq_b.delete(); exp_q.delete();
  endtask

  task automatic pulse_reset();
    clrn = 1'b0; #5; clrn = 1'b1; model_reset(); #5;
  endtask

  // One key press: model update, expected push, then a clock pulse with time_bcd held
  task automatic press(input bit sel, input logic [15:0] t);
    exp_t e;
    bit   cap = 1'b0;
    time_bcd = t;
    if (ovf && mst[sel] != 3) begin
      mst[sel] = 3; cap = 1'b1;
    end else begin
      case (mst[sel])
        0:       mst[sel] = 1;
        1:       begin mst[sel] = 2; cap = 1'b1; end
        2:       mst[sel] = 1;
        default: mst[sel] = 3;
      endcase
    end
    if (cap && sel) begin
      lq_b.push_front(t); if (lq_b.size() > 2) void'(lq_b.pop_back());
    end else if (cap) begin
      lq_a.push_front(t); if (lq_a.size() > 4) void'(lq_a.pop_back());
    end
    e.en   = (mst[sel] == 1);
    e.halt = (mst[sel] == 3);
    e.cnt  = sel ? 3'(lq_b.size()) : 3'(lq_a.size());
    exp_q.push_back(e);
    #10; if (sel) clk_b = 1'b1; else clk_a = 1'b1;
    #10; clk_a = 1'b0; clk_b = 1'b0;
    #10;
  endtask

  task automatic test_reset();
    clrn = 1'b0; ovf = 1'b0; clk_a = 1'b0; clk_b = 1'b0; time_bcd = 16'h0000;
    rd_idx_a = 2'd0; rd_idx_b = 1'b0; model_reset();
    #5;
    n_cmp++; if ({enable_a, halted_a, lap_cnt_a} !== 5'b0) begin
      n_err++; $display("FAIL reset_a: got %b want 00000", {enable_a, halted_a, lap_cnt_a});
    end
    n_cmp++; if ({enable_b, halted_b, lap_cnt_b} !== 4'b0) begin
      n_err++; $display("FAIL reset_b: got %b want 0000", {enable_b, halted_b, lap_cnt_b});
    end
    n_cmp++; if (lap_time_a !== 16'h0000) begin
      n_err++; $display("FAIL reset_lap: got %h want 0000", lap_time_a);
    end
    clrn = 1'b1; #5;
  endtask

  task automatic test_basic();
    logic [15:0] vals[3] = '{16'h0000, 16'h1234, 16'h1300};
    logic        en_want[3] = '{1'b1, 1'b0, 1'b1};
    exp_t e, o;
    for (int i = 0; i < 3; i++) begin
      press(1'b0, vals[i]);
      e = exp_q.pop_front(); o = observe(1'b0);
      n_cmp++; if (o !== e || o.en !== en_want[i]) begin
        n_err++; $display("FAIL basic_press%0d: got %b want %b en %b", i, o, e, en_want[i]);
      end
    end
    n_cmp++; if (lap_cnt_a !== 3'd1) begin
      n_err++; $display("FAIL basic_cnt: got %0d want 1", lap_cnt_a);
    end
    for (int i = 0; i < 2; i++) begin
      set_rd(1'b0, i); #1;
      n_cmp++; if (lap_time_a !== ((i == 0) ? 16'h1234 : 16'h0000)) begin
        n_err++; $display("FAIL basic_rd%0d: got %h want %h", i, lap_time_a, model_lap(1'b0, i));
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 2; j++) begin
        press(1'b0, (j == 0) ? 16'(k) * 16'h0101 : 16'h9999);
        e = exp_q.pop_front(); o = observe(1'b0);
        n_cmp++; if (o !== e) begin
          n_err++; $display("FAIL wrap_press%0d_%0d: got %b want %b", k, j, o, e);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      set_rd(1'b0, i); #1;
      n_cmp++; if (lap_time_a !== 16'(5 - i) * 16'h0101 || lap_time_a !== model_lap(1'b0, i)) begin
        n_err++; $display("FAIL wrap_rd%0d: got %h want %h", i, lap_time_a, model_lap(1'b0, i));
      end
    end
  endtask

  task automatic test_halt_run();
    exp_t e, o;
    ovf = 1'b1;
    for (int p = 0; p < 4; p++) begin
      press(1'b0, (p == 0) ? 16'h0000 : 16'h7777);
      e = exp_q.pop_front(); o = observe(1'b0);
      n_cmp++; if (o !== e || o.halt !== 1'b1 || o.en !== 1'b0) begin
        n_err++; $display("FAIL halt_press%0d: got %b want %b", p, o, e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      set_rd(1'b0, i); #1;
      n_cmp++; if (lap_time_a !== model_lap(1'b0, i)) begin
        n_err++; $display("FAIL halt_rd%0d: got %h want %h", i, lap_time_a, model_lap(1'b0, i));
      end
    end
    ovf = 1'b0;
  endtask

  task automatic test_idle_ovf();
    exp_t e, o;
    pulse_reset();
    ovf = 1'b1;
    press(1'b0, 16'h4321);
    e = exp_q.pop_front(); o = observe(1'b0);
    n_cmp++; if (o !== e || o !== exp_t'({1'b0, 1'b1, 3'd1})) begin
      n_err++; $display("FAIL idle_ovf: got %b want %b", o, e);
    end
    set_rd(1'b0, 0); #1;
    n_cmp++; if (lap_time_a !== 16'h4321) begin
      n_err++; $display("FAIL idle_ovf_rd: got %h want 4321", lap_time_a);
    end
    ovf = 1'b0;
  endtask

  task automatic test_clrn_mid();
    logic [15:0] vals[4] = '{16'h0000, 16'h0111, 16'h0000, 16'h0222};
    exp_t e, o;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b0, vals[i]);
      e = exp_q.pop_front(); o = observe(1'b0);
      n_cmp++; if (o !== e) begin
        n_err++; $display("FAIL clrn_setup%0d: got %b want %b", i, o, e);
      end
    end
    clrn = 1'b0; #1;
    n_cmp++; if ({enable_a, halted_a, lap_cnt_a} !== 5'b0) begin
      n_err++; $display("FAIL clrn_async: got %b want 00000", {enable_a, halted_a, lap_cnt_a});
    end
    for (int i = 0; i < 4; i++) begin
      set_rd(1'b0, i); #0.5;
      n_cmp++; if (lap_time_a !== 16'h0000) begin
        n_err++; $display("FAIL clrn_rd%0d: got %h want 0000", i, lap_time_a);
      end
    end
    #2; clrn = 1'b1; model_reset(); #5;
    press(1'b0, 16'h0000);
    e = exp_q.pop_front(); o = observe(1'b0);
    n_cmp++; if (o !== e || enable_a !== 1'b1) begin
      n_err++; $display("FAIL clrn_restart: got %b want %b", o, e);
    end
  endtask

  task automatic test_depth2();
    exp_t e, o;
    pulse_reset();
    for (int k = 1; k <= 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        press(1'b1, (j == 0) ? 16'h5555 : 16'(k) * 16'h0011);
        e = exp_q.pop_front(); o = observe(1'b1);
        n_cmp++; if (o !== e) begin
          n_err++; $display("FAIL d2_press%0d_%0d: got %b want %b", k, j, o, e);
        end
      end
    end
    n_cmp++; if (lap_cnt_b !== 2'd2) begin
      n_err++; $display("FAIL d2_cnt: got %0d want 2", lap_cnt_b);
    end
    for (int i = 0; i < 2; i++) begin
      set_rd(1'b1, i); #1;
      n_cmp++; if (read_lap(1'b1) !== ((i == 0) ? 16'h0033 : 16'h0022)) begin
        n_err++; $display("FAIL d2_rd%0d: got %h want %h", i, read_lap(1'b1), model_lap(1'b1, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_halt_run();
    test_idle_ovf();
    test_clrn_mid();
    test_depth2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/press_run_ctrl.md
# press_run_ctrl

Run-control and lap-capture stage between the debounced start/stop key and the stopwatch counting chain. Each debounced key press (rising edge of TFF_clk) steps a small state machine: it drives the count-enable into the 100 Hz divider and freezes the BCD time into a circular lap buffer on every stop. Stored laps are read back combinationally for the scan/7-segment path. The block latches terminally once the counter reports its 59.99 s carry.

## Interface
- DEPTH, 4: number of lap entries; power of two, 2..8.
- TW, 16: lap word width, {dsec, sec, secd, secm}, 4 bits BCD each.
- TFF_clk  in  1  clock; rising edge = one debounced key press.
- clrn  in  1  reset; asynchronous, active-low.
- time_bcd  in  TW  live counter digits {dsec, sec, secd, secm}.
- ovf  in  1  counter carry (cn); level, sticky until counter reset.
- rd_idx  in  log2(DEPTH)  lap read index; 0 = most recent, 1 = previous, and so on.
- enable  out  1  count enable to the 100 Hz divider; 1 = counting.
- lap_time  out  TW  lap entry selected by rd_idx; combinational.
- lap_cnt  out  log2(DEPTH)+1  valid entries, saturating at DEPTH.
- halted  out  1  terminal state flag.

## Operation
- States:
  - IDLE: reset state; nothing captured.
  - RUN: enable = 1.
  - STOP: paused; at least one lap captured.
  - HALT: terminal.
- Transitions, evaluated on each rising TFF_clk:
  - ovf = 1 in any state other than HALT: go to HALT. enable = 0. Capture time_bcd as a lap. Takes priority over every other rule.
  - IDLE → RUN: enable goes to 1. No capture.
  - RUN → STOP: enable goes to 0. Capture time_bcd.
  - STOP → RUN: enable goes to 1. No capture.
  - HALT: all presses ignored; only clrn leaves HALT.
- Capture:
  - Write time_bcd at wr_ptr, then wr_ptr = wr_ptr + 1 mod DEPTH.
  - lap_cnt = min(lap_cnt + 1, DEPTH).
  - When full, the oldest entry is overwritten.
- Read:
  - lap_time = buf[(wr_ptr − 1 − rd_idx) mod DEPTH] when rd_idx < lap_cnt.
  - Otherwise lap_time = 16'h0000, which displays 00.00.
- halted = 1 exactly when the state is HALT.
- Stored values are not checked as BCD; they are stored as received.

## Timing
- Reset values, asserted asynchronously while clrn = 0:
  - State IDLE; enable = 0; halted = 0; lap_cnt = 0; wr_ptr = 0.
  - All buffer entries 0, so lap_time = 0.
- Latency:
  - enable, halted, lap_cnt and buffer contents update on the same rising TFF_clk edge as the press: one press, one edge.
  - lap_time follows rd_idx and buffer contents with no clock.
- Capture sampling:
  - time_bcd is sampled at the rising TFF_clk edge.
  - The counter runs on an unrelated 100 Hz clock. System integration keeps time_bcd stable for at least 1 µs around the press edge.
  - The bench holds time_bcd constant for ±10 ns around each edge.
- ovf and a press at the same edge: the HALT rule wins. The value captured is the time_bcd present at that edge.
- clrn asserted mid-operation, in any state: immediate return to the reset values. No capture occurs.
- clrn deasserting near a TFF_clk edge: that press may be lost. This is acceptable because presses are at least 120 ms apart.

## Structure
- Shared package holds:
  - State encoding: IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2, HALT = 2'd3.
  - Lap word width and field offsets: dsec [15:12], sec [11:8], secd [7:4], secm [3:0].
  - Default DEPTH.
- Sub-module lap_buf:
  - DEPTH × TW register file, asynchronously cleared by clrn.
  - Write port: we, wr_ptr, time_bcd.
  - Read port: one combinational read address.
- The top level holds the FSM, wr_ptr, lap_cnt, and the read-address arithmetic including the rd_idx < lap_cnt check.

## Test plan
- Reset, then three presses with time_bcd = 16'h0000, 16'h1234, 16'h1300:
  - enable sequence is 1, 0, 1.
  - lap_cnt = 1.
  - lap_time at rd_idx = 0 is 16'h1234.
  - rd_idx = 1 gives 16'h0000 (unused entry).
- Five run/stop pairs with capture values 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505:
  - lap_cnt = 4.
  - rd_idx 0..3 gives 16'h0505, 16'h0404, 16'h0303, 16'h0202; 16'h0101 has been overwritten.
- In RUN, set ovf = 1 with time_bcd = 16'h0000 and press:
  - halted = 1, enable = 0.
  - Newest lap = 16'h0000.
  - Three further presses leave enable, lap_cnt and the buffer unchanged.
- In IDLE, set ovf = 1 and press:
  - Goes directly to HALT.
  - lap_cnt = 1; enable never rises.
- Assert clrn for 5 ns in STOP with lap_cnt = 2:
  - enable, lap_cnt and halted are 0 immediately, before any clock edge.
  - All rd_idx read 16'h0000.
  - The next press gives enable = 1.
- Set DEPTH = 2 and stop three times:
  - lap_cnt saturates at 2.
  - rd_idx = 1 holds the second capture.
